// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count_ctrl front-end: FSM state, div_sel
// encoding and the fixed prescale divisors.
package count_ctrl_pkg;

  typedef enum logic {
    ST_PAUSED = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  localparam logic [1:0] DIV_SEL_1      = 2'd0;
  localparam logic [1:0] DIV_SEL_16     = 2'd1;
  localparam logic [1:0] DIV_SEL_256    = 2'd2;
  localparam logic [1:0] DIV_SEL_CUSTOM = 2'd3;

  localparam int DIV_FIXED_16  = 16;
  localparam int DIV_FIXED_256 = 256;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, debouncer and registered press pulse.
// Debouncer present only when COUNT_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam bit DEBOUNCE_EN = 1'b1;
`else
  localparam bit DEBOUNCE_EN = 1'b0;
`endif

  logic sync_q1, sync_q2;
  logic stable, stable_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  if (DEBOUNCE_EN && (DEBOUNCE_CYCLES >= 1)) begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          level_q;

    // The level flips on the sample that brings the disagreement run to DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q <= 1'b0;
        cnt     <= '0;
      end else if (sync_q2 == level_q) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= ~level_q;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign stable = level_q;
  end else begin : g_bypass
    assign stable = sync_q2;
  end

  // Only rising edges of the accepted level count as presses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Counter control front-end: run/pause FSM, prescaler, step and load strobes.
// Button debouncing is enabled by defining COUNT_CTRL_DEBOUNCE_EN.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int PRESCALE_W      = 16,
  parameter int PRESCALE_DIV    = 1000,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       load_btn,
  input  logic [7:0] load_sw,
  input  logic [1:0] div_sel,
  output logic       count_en,
  output logic       load_en,
  output logic [7:0] load_val,
  output logic       running
);

  logic run_press, step_press, load_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .clk(clk), .rst_n(rst_n), .btn(run_btn), .press(run_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk(clk), .rst_n(rst_n), .btn(step_btn), .press(step_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_btn (
    .clk(clk), .rst_n(rst_n), .btn(load_btn), .press(load_press)
  );

  logic [7:0] load_sw_q1, load_sw_q2;
  logic [1:0] div_sel_q1, div_sel_q2, div_sel_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_sw_q1 <= '0;
      load_sw_q2 <= '0;
      div_sel_q1 <= '0;
      div_sel_q2 <= '0;
    end else begin
      load_sw_q1 <= load_sw;
      load_sw_q2 <= load_sw_q1;
      div_sel_q1 <= div_sel;
      div_sel_q2 <= div_sel_q1;
    end
  end

  logic [PRESCALE_W-1:0] div_m1, presc;
  logic                  tick, div_changed;

  always_comb begin
    case (div_sel_q2)
      DIV_SEL_1:   div_m1 = '0;
      DIV_SEL_16:  div_m1 = PRESCALE_W'(DIV_FIXED_16 - 1);
      DIV_SEL_256: div_m1 = PRESCALE_W'(DIV_FIXED_256 - 1);
      default:     div_m1 = PRESCALE_W'(PRESCALE_DIV - 1);
    endcase
  end

  assign tick        = (presc == div_m1);
  assign div_changed = (div_sel_q2 != div_sel_prev);

  state_t state;

  // Priority load > run > step; load_en and count_en are never set together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_PAUSED;
      presc        <= '0;
      count_en     <= 1'b0;
      load_en      <= 1'b0;
      load_val     <= '0;
      div_sel_prev <= '0;
    end else begin
      div_sel_prev <= div_sel_q2;
      load_en      <= 1'b0;
      count_en     <= 1'b0;
      if (load_press) begin
        state    <= ST_PAUSED;
        presc    <= '0;
        load_en  <= 1'b1;
        load_val <= load_sw_q2;
      end else if (run_press) begin
        state <= (state == ST_RUN) ? ST_PAUSED : ST_RUN;
        presc <= '0;
      end else if (state == ST_RUN) begin
        if (div_changed) begin
          presc <= '0;
        end else begin
          count_en <= tick;
          presc    <= tick ? '0 : presc + 1'b1;
        end
      end else begin
        presc    <= '0;
        count_en <= step_press;
      end
    end
  end

  assign running = (state == ST_RUN);

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Control front-end for the 8-bit up-counter in the TinyTapeout top level. It conditions raw button and switch inputs from `ui_in`: two-flop synchronisation, debounce and press-edge detection. From those it produces the counter's `enable` and `load_en`/`load` strobes, paced by a selectable prescaler. It sits directly upstream of the counter and replaces the hard-wired `load`/`load_en` constants and the direct `ena` enable.

## Interface
- `PRESCALE_W`, 16: width of the prescaler counter.
- `PRESCALE_DIV`, 1000: divisor used when `div_sel`=3; legal range 2..2^PRESCALE_W.
- `DEBOUNCE_CYCLES`, 1024: consecutive stable synchronised samples required to accept a button level change; minimum 1.
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `run_btn`  in  1  raw button; each press toggles run/pause.
- `step_btn`  in  1  raw button; each press advances the count by one while paused.
- `load_btn`  in  1  raw button; each press loads `load_sw`.
- `load_sw`  in  8  raw switches; the load value.
- `div_sel`  in  2  prescale select: 0 gives /1, 1 gives /16, 2 gives /256, 3 gives /PRESCALE_DIV.
- `count_en`  out  1  counter enable; a one-cycle pulse, or held high at /1.
- `load_en`  out  1  one-cycle load strobe.
- `load_val`  out  8  registered load value; stable while `load_en` is high.
- `running`  out  1  high in the RUN state.

## Operation
- **Input conditioning.** `load_sw` and `div_sel` each pass through a 2-flop synchroniser. Each button passes through a 2-flop synchroniser and then a debouncer.
- **Debouncer.** Holds a stable level, reset value 0. A counter increments while the synchronised input differs from the stable level. It clears whenever the two agree. When the count reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- **Press event.** A press is a 0→1 transition of the stable level. Releases are ignored.
- **FSM states.**
  - PAUSED is the reset state.
  - RUN.
- **Transitions.**
  - A run press toggles between PAUSED and RUN.
  - A load press sets PAUSED regardless of the current state.
- **Event priority in a single cycle:** load > run > step. The lower-priority events are dropped.
- **Load.** `load_val` takes the synchronised `load_sw` and `load_en` pulses for one cycle. The prescaler clears.
- **Step.** A step press in PAUSED gives one `count_en` pulse. A step press in RUN is ignored.
- **Prescaler.**
  - Counts 0..DIV-1 while in RUN and wraps to 0.
  - Tick when the count equals DIV-1.
  - Cleared on entry to RUN, on load, and on any change of synchronised `div_sel`.
  - Held at 0 in PAUSED.
- **`count_en` (registered).** Asserted when (RUN and tick) or a step is accepted. Forced low in any cycle in which `load_en` is asserted.
- **Mutual exclusion.** `count_en` and `load_en` are never high in the same cycle.
- **Reset.** A reset mid-operation immediately clears state, prescaler, debouncers and all outputs. Any pending press is discarded.

## Timing
- **Reset values:**
  - `count_en`=0
  - `load_en`=0
  - `load_val`=8'h00
  - `running`=0
- **Press latency.** A raw button held high from clock edge E produces its output effect at edge E+3+DEBOUNCE_CYCLES. The effect is a `load_en` pulse, a `count_en` step pulse, or a `running` change.
- **Divide-by-N rate.** In RUN with divide N ≥ 2, `count_en` pulses once every N cycles. The first pulse comes N cycles after `running` rises.
- **Divide-by-1.** `count_en` is high in every RUN cycle, starting the cycle after `running` rises.
- **Load value.** `load_val` reflects the `load_sw` level present 2 cycles before the accepted load press.
- **Pause.** After a pause, `count_en` is low from the same edge at which `running` falls.

## Configuration
- `COUNT_CTRL_DEBOUNCE_EN` defined:
  - Debouncers are present, as described above.
- `COUNT_CTRL_DEBOUNCE_EN` undefined:
  - The stable level equals the synchronised input.
  - Press latency becomes 3 edges.
  - DEBOUNCE_CYCLES is ignored.
  - Intended for fast simulation and for FPGA use with clean inputs.

## Structure
- Package `count_ctrl_pkg`:
  - FSM state typedef (PAUSED, RUN).
  - `div_sel` encoding constants.
  - Fixed divisors 16 and 256.
- Sub-module `btn_debounce`: synchroniser, debouncer and press-edge detector. Instantiated three times, once per button.
- Top `count_ctrl`: FSM, prescaler, `load_sw`/`div_sel` synchronisers and output registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and PRESCALE_DIV=5.

- **Reset.** Assert `rst_n`=0 mid-RUN → all outputs 0 asynchronously, state PAUSED. After release, no `count_en` until a run press.
- **Debounce.** `run_btn` high for 3 cycles, then low → no `running` change. Held high 10 cycles → `running`=1 at edge 7 after the first high sample.
- **Prescaler.** RUN with `div_sel`=3 → `count_en` pulses every 5 cycles, first pulse 5 cycles after `running` rises. `div_sel`=0 → `count_en` continuously high. Change to `div_sel`=1 → prescaler restarts and pulses every 16 cycles.
- **Load.** `load_sw`=8'hC5, load press while RUN → one-cycle `load_en` with `load_val`=8'hC5, `running`=0, `count_en` low in that cycle and afterwards.
- **Step.** PAUSED, 3 step presses → exactly 3 single-cycle `count_en` pulses. A step press in RUN → no extra pulse.
- **Simultaneous presses.** Load and run presses accepted in the same cycle → load wins, state PAUSED. With COUNT_CTRL_DEBOUNCE_EN undefined, the same scenarios hold with 3-edge press latency.
